// File: rtl/fu_mul_pipe_pkg.sv
// Shared types for the pipelined RV32M multiply unit: op encoding, request/response
// records and the operand-signedness rules used by the multiplier core.
package fu_mul_pipe_pkg;

  localparam int MUL_OP_W     = 2;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_ROB_W    = 5;
  localparam int DEF_PREG_W   = 6;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef struct packed {
    mul_op_t                 op;
    logic [DEF_XLEN-1:0]     rs1_v;
    logic [DEF_XLEN-1:0]     rs2_v;
    logic [DEF_ROB_W-1:0]    rob_id;
    logic [DEF_PREG_W-1:0]   pd;
  } mul_req_t;

  typedef struct packed {
    logic [DEF_XLEN-1:0]     result;
    logic [DEF_ROB_W-1:0]    rob_id;
    logic [DEF_PREG_W-1:0]   pd;
  } mul_resp_t;

  function automatic logic rs1_signed(mul_op_t op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic rs2_signed(mul_op_t op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/fu_mul_pipe_if.sv
// Issue and result channels of the multiply unit, each a valid/ready handshake.
interface fu_mul_pipe_if
  import fu_mul_pipe_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int ROB_W  = DEF_ROB_W,
  parameter int PREG_W = DEF_PREG_W
);

  logic               in_valid;
  logic               in_ready;
  mul_op_t            in_op;
  logic [XLEN-1:0]    in_rs1_v;
  logic [XLEN-1:0]    in_rs2_v;
  logic [ROB_W-1:0]   in_rob_id;
  logic [PREG_W-1:0]  in_pd;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [ROB_W-1:0]   out_rob_id;
  logic [PREG_W-1:0]  out_pd;

  modport master (
    output in_valid, in_op, in_rs1_v, in_rs2_v, in_rob_id, in_pd, out_ready,
    input  in_ready, out_valid, out_result, out_rob_id, out_pd
  );

  modport slave (
    input  in_valid, in_op, in_rs1_v, in_rs2_v, in_rob_id, in_pd, out_ready,
    output in_ready, out_valid, out_result, out_rob_id, out_pd
  );

endinterface

// File: rtl/fu_mul_pipe_mul_core.sv
// Combinational XLEN x XLEN multiplier returning the low or high product half by op.
module fu_mul_pipe_mul_core
  import fu_mul_pipe_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  mul_op_t          op,
  input  logic [XLEN-1:0]  rs1_v,
  input  logic [XLEN-1:0]  rs2_v,
  output logic [XLEN-1:0]  result
);

  logic signed [XLEN:0]      rs1_ext;
  logic signed [XLEN:0]      rs2_ext;
  logic signed [2*XLEN+1:0]  product;
  logic [1:0]                unused_product_top;

  // One extra bit lets a single signed multiply cover all four signedness mixes.
  assign rs1_ext = {rs1_signed(op) & rs1_v[XLEN-1], rs1_v};
  assign rs2_ext = {rs2_signed(op) & rs2_v[XLEN-1], rs2_v};

  assign product = $signed({{(XLEN+1){rs1_ext[XLEN]}}, rs1_ext})
                 * $signed({{(XLEN+1){rs2_ext[XLEN]}}, rs2_ext});

  always_comb begin
    result = product[2*XLEN-1:XLEN];
    if (op == MUL_OP_MUL) begin
      result = product[XLEN-1:0];
    end
  end

  assign unused_product_top = product[2*XLEN+1:2*XLEN];

endmodule

// File: rtl/fu_mul_pipe.sv
// Rigid STAGES-deep multiply pipeline: product formed in stage 0, later stages retime it,
// whole pipe freezes on result backpressure and is cleared by flush or reset.
module fu_mul_pipe
  import fu_mul_pipe_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int STAGES = 3,
  parameter int ROB_W  = DEF_ROB_W,
  parameter int PREG_W = DEF_PREG_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  fu_mul_pipe_if.slave   fu,
  output logic           busy
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    result;
    logic [ROB_W-1:0]   rob_id;
    logic [PREG_W-1:0]  pd;
  } stage_t;

  stage_t             stage_reg [STAGES];
  logic [STAGES-1:0]  valid_vec;
  logic               stall;
  logic               accept;
  logic [XLEN-1:0]    product;

  fu_mul_pipe_mul_core #(.XLEN(XLEN)) u_mul_core (
    .op     (fu.in_op),
    .rs1_v  (fu.in_rs1_v),
    .rs2_v  (fu.in_rs2_v),
    .result (product)
  );

  assign stall        = stage_reg[STAGES-1].valid && !fu.out_ready;
  assign fu.in_ready  = !stall && !flush;
  assign accept       = fu.in_valid && fu.in_ready;

  // A result presented during a flush cycle must not be taken by the arbiter.
  assign fu.out_valid  = stage_reg[STAGES-1].valid && !flush;
  assign fu.out_result = stage_reg[STAGES-1].result;
  assign fu.out_rob_id = stage_reg[STAGES-1].rob_id;
  assign fu.out_pd     = stage_reg[STAGES-1].pd;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_t stage_in;

      if (gi == 0) begin : g_head
        assign stage_in = {accept, product, fu.in_rob_id, fu.in_pd};
      end else begin : g_body
        assign stage_in = stage_reg[gi-1];
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          stage_reg[gi] <= '0;
        end else if (flush) begin
          stage_reg[gi].valid <= 1'b0;
        end else if (!stall) begin
          stage_reg[gi] <= stage_in;
        end
      end

      assign valid_vec[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign busy = |valid_vec;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Drives three multiply pipes (STAGES 1, 3, 5) with the same directed ops and checks each
// against a per-instance scoreboard of hand-computed results and exact issue latency.
module tb_fu_mul_pipe;
  import fu_mul_pipe_pkg::*;

  localparam int NDUT = 3;

  function automatic int stg_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 5;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  mul_op_t     in_op = MUL_OP_MUL;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] cur_exp = '0;
  logic [4:0]  rob = '0;
  logic [5:0]  pd = '0;

  logic [NDUT-1:0] o_valid, o_in_ready, o_busy;
  logic [31:0]     o_result [NDUT];
  logic [4:0]      o_rob    [NDUT];
  logic [5:0]      o_pd     [NDUT];

  always #5 clk = ~clk;

  fu_mul_pipe_if #(.XLEN(32), .ROB_W(5), .PREG_W(6)) bus [NDUT] ();

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int S = (gi == 0) ? 1 : (gi == 1) ? 3 : 5;
      assign bus[gi].in_valid  = in_valid;
      assign bus[gi].in_op     = in_op;
      assign bus[gi].in_rs1_v  = rs1;
      assign bus[gi].in_rs2_v  = rs2;
      assign bus[gi].in_rob_id = rob;
      assign bus[gi].in_pd     = pd;
      assign bus[gi].out_ready = out_ready;
      assign o_valid[gi]    = bus[gi].out_valid;
      assign o_in_ready[gi] = bus[gi].in_ready;
      assign o_result[gi]   = bus[gi].out_result;
      assign o_rob[gi]      = bus[gi].out_rob_id;
      assign o_pd[gi]       = bus[gi].out_pd;

      fu_mul_pipe #(.XLEN(32), .STAGES(S), .ROB_W(5), .PREG_W(6)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .fu    (bus[gi]),
        .busy  (o_busy[gi])
      );
    end
  endgenerate

  typedef struct {
    mul_resp_t resp;
    int        cyc;
    int        stalls;
  } exp_t;

  exp_t sb_q [NDUT][$];
  int   stalls [NDUT];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s stages=%0d cyc=%0d actual=%h required=%h", name, stg_of(k), cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) started <= 1'b1;
  end

  // Monitor: the model says when each accepted op must appear; compare on every falling edge.
  always @(negedge clk) begin
    bit   mv;
    int   el;
    exp_t h;
    exp_t e;
    if (started) begin
      for (int k = 0; k < NDUT; k++) begin
        if (!rst) begin
          sb_q[k].delete();
        end else begin
          mv = 1'b0;
          if (sb_q[k].size() > 0) begin
            h  = sb_q[k][0];
            el = cyc - h.cyc - (stalls[k] - h.stalls);
            mv = (el == stg_of(k));
          end
          check("busy", k, 32'(o_busy[k]), 32'(sb_q[k].size() > 0));
          if (flush) begin
            check("flush_out_valid", k, 32'(o_valid[k]), 32'd0);
            check("flush_in_ready", k, 32'(o_in_ready[k]), 32'd0);
            sb_q[k].delete();
          end else begin
            check("out_valid", k, 32'(o_valid[k]), 32'(mv));
            check("in_ready", k, 32'(o_in_ready[k]), 32'(!(mv && !out_ready)));
            if (mv) begin
              check("result", k, o_result[k], h.resp.result);
              check("rob_id", k, 32'(o_rob[k]), 32'(h.resp.rob_id));
              check("pd", k, 32'(o_pd[k]), 32'(h.resp.pd));
              if (out_ready) begin
                void'(sb_q[k].pop_front());
                $display("stages=%0d cyc=%0d result rob=%0d pd=%0d value=%h",
                         stg_of(k), cyc, o_rob[k], o_pd[k], o_result[k]);
              end else begin
                stalls[k]++;
              end
            end
            if (in_valid && !(mv && !out_ready)) begin
              e.resp.result = cur_exp;
              e.resp.rob_id = rob;
              e.resp.pd     = pd;
              e.cyc         = cyc;
              e.stalls      = stalls[k];
              sb_q[k].push_back(e);
            end
          end
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [5:0] p, input logic [31:0] x);
    in_valid = 1'b1;
    in_op    = op;
    rs1      = a;
    rs2      = b;
    rob      = r;
    pd       = p;
    cur_exp  = x;
    $display("issue op=%0d rs1=%h rs2=%h rob=%0d pd=%0d expect=%h", op, a, b, r, p, x);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int left;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single MUL and the signedness corner cases
    drive(MUL_OP_MUL, 32'd7, 32'd6, 5'd1, 6'd2, 32'd42);
    idle(7);
    drive(MUL_OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 6'd3, 32'h00000001);
    drive(MUL_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 6'd4, 32'h00000000);
    drive(MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 6'd5, 32'hFFFFFFFF);
    drive(MUL_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 6'd6, 32'hFFFFFFFE);
    drive(MUL_OP_MULH,   32'h80000000, 32'h80000000, 5'd6, 6'd7, 32'h40000000);
    idle(8);

    // Eight ops back to back
    drive(MUL_OP_MUL,   32'd1,        32'd1,        5'd7,  6'd10, 32'd1);
    drive(MUL_OP_MUL,   32'd2,        32'd3,        5'd8,  6'd11, 32'd6);
    drive(MUL_OP_MUL,   32'd10,       32'd10,       5'd9,  6'd12, 32'd100);
    drive(MUL_OP_MUL,   32'd12,       32'd12,       5'd10, 6'd13, 32'd144);
    drive(MUL_OP_MUL,   32'h00010000, 32'h00010000, 5'd11, 6'd14, 32'h00000000);
    drive(MUL_OP_MULHU, 32'h00010000, 32'h00010000, 5'd12, 6'd15, 32'h00000001);
    drive(MUL_OP_MUL,   32'hFFFFFFFE, 32'd3,        5'd13, 6'd16, 32'hFFFFFFFA);
    drive(MUL_OP_MULH,  32'hFFFFFFFE, 32'd3,        5'd14, 6'd17, 32'hFFFFFFFF);
    idle(8);

    // Backpressure with results in flight
    drive(MUL_OP_MUL,   32'd5,        32'd5, 5'd15, 6'd20, 32'd25);
    drive(MUL_OP_MUL,   32'd9,        32'd9, 5'd16, 6'd21, 32'd81);
    drive(MUL_OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd17, 6'd22, 32'h00000001);
    drive(MUL_OP_MULH,  32'hFFFFFFFF, 32'd2, 5'd18, 6'd23, 32'hFFFFFFFF);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    idle(8);

    // Flush with three ops in flight and a request in the flush cycle
    drive(MUL_OP_MUL, 32'd3, 32'd4, 5'd19, 6'd30, 32'd12);
    drive(MUL_OP_MUL, 32'd4, 32'd5, 5'd20, 6'd31, 32'd20);
    drive(MUL_OP_MUL, 32'd5, 32'd6, 5'd21, 6'd32, 32'd30);
    flush = 1'b1;
    drive(MUL_OP_MUL, 32'd6, 32'd7, 5'd22, 6'd33, 32'd42);
    flush = 1'b0;
    idle(8);

    // One-cycle reset mid-stream, then a fresh op
    drive(MUL_OP_MUL, 32'd2, 32'd2, 5'd23, 6'd40, 32'd4);
    drive(MUL_OP_MUL, 32'd3, 32'd3, 5'd24, 6'd41, 32'd9);
    drive(MUL_OP_MUL, 32'd4, 32'd4, 5'd25, 6'd42, 32'd16);
    rst = 1'b0;
    drive(MUL_OP_MUL, 32'd8, 32'd8, 5'd26, 6'd43, 32'd64);
    rst = 1'b1;
    idle(1);
    drive(MUL_OP_MUL, 32'd11, 32'd13, 5'd27, 6'd44, 32'd143);
    idle(8);

    left = 30;
    while (left > 0 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) > 0) begin
      tick();
      left--;
    end
    for (int k = 0; k < NDUT; k++) begin
      check("drain", k, 32'(sb_q[k].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
